// File: rtl/ace_mem_pkg.sv
// Shared types for the RAM port arbiter: access owners, arbiter FSM states, pipeline tag.
// No logic here; latency and backpressure live in the modules that import it.
// Tag width is fixed by owner_t plus a single write flag.
package ace_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        owner_t owner;
        logic   we;
    } tag_t;

endpackage

// File: rtl/ram_arb_pipe.sv
// Routes RAM read data back to the owner of each granted access and pulses its ack.
// Latency: tag in at grant cycle N, ack and data out in cycle N+2.
// No backpressure: accepts one tag per cycle, acks are single-cycle pulses.
module ram_arb_pipe
    import ace_mem_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  tag_t          issue_tag,
    input  logic [DW-1:0] ram_dout,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout
);

    tag_t s1_tag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_tag   <= '{owner: OWN_NONE, we: 1'b0};
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_data <= '0;
            cpu_dout <= '0;
        end else begin
            s1_tag  <= issue_tag;
            vid_ack <= (s1_tag.owner == OWN_VID);
            cpu_ack <= (s1_tag.owner == OWN_CPU);
            // ram_dout is valid one cycle after the address, i.e. while s1_tag describes it
            if (s1_tag.owner == OWN_VID)
                vid_data <= ram_dout;
            if ((s1_tag.owner == OWN_CPU) && !s1_tag.we)
                cpu_dout <= ram_dout;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port sync RAM between video fetch and Z80 CPU, with optional zero-fill after reset.
// Latency: grant is combinational in cycle N, ack/data in cycle N+2; one access per cycle.
// Backpressure: video has fixed priority; the CPU waits (cpu_wait) but wins after CPU_MAX_WAIT losses.
module ram_port_arbiter
    import ace_mem_pkg::*;
#(
    parameter int AW             = 10,
    parameter int DW             = 8,
    parameter int CPU_MAX_WAIT   = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_gnt,
    output logic          cpu_wait,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int            SW         = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_MAX_WAIT);
    localparam state_t        ST_INIT    = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [SW-1:0] starve_cnt;
    logic          cpu_win;
    tag_t          issue_tag;

    // RAM strobes and grants are held quiet while reset is asserted
    always_comb begin
        state_nxt = state;
        cpu_win   = 1'b0;
        vid_gnt   = 1'b0;
        cpu_gnt   = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_a     = '0;
        ram_din   = '0;
        issue_tag = '{owner: OWN_NONE, we: 1'b0};
        if (reset_n) begin
            unique case (state)
                ST_CLEAR: begin
                    ram_ce = 1'b1;
                    ram_we = 1'b1;
                    ram_a  = clr_cnt;
                    if (clr_cnt == {AW{1'b1}})
                        state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    cpu_win = cpu_req && (!vid_req || (starve_cnt == STARVE_MAX));
                    if (cpu_win) begin
                        cpu_gnt   = 1'b1;
                        ram_ce    = 1'b1;
                        ram_we    = cpu_we;
                        ram_a     = cpu_addr;
                        ram_din   = cpu_we ? cpu_din : '0;
                        issue_tag = '{owner: OWN_CPU, we: cpu_we};
                    end else if (vid_req) begin
                        vid_gnt   = 1'b1;
                        ram_ce    = 1'b1;
                        ram_a     = vid_addr;
                        issue_tag = '{owner: OWN_VID, we: 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_INIT;
            clr_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            // counts every lost cycle, including those spent behind the clear sequence
            if (cpu_req && !cpu_gnt)
                starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;
        end
    end

    assign cpu_wait = cpu_req & ~cpu_gnt;
    assign busy     = (state == ST_CLEAR);

    ram_arb_pipe #(
        .DW (DW)
    ) u_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .issue_tag (issue_tag),
        .ram_dout  (ram_dout),
        .vid_ack   (vid_ack),
        .vid_data  (vid_data),
        .cpu_ack   (cpu_ack),
        .cpu_dout  (cpu_dout)
    );

endmodule
